sweep_compare_decode: RTL and testbench
=======================================

Name: sweep_compare_decode

Overview:
- Clocked, parametrised stimulus/check engine for the lab comparator and decoder blocks.
- On command, sweeps an internal WIDTH-bit counter through every value from 0 to 2^WIDTH-1, one value per enabled cycle.
- Each swept value is compared against a latched target using a selectable relation, and its low DEC_BITS are one-hot decoded.
- Hits are counted, and completion is flagged for the lab top level or a bench.

Parameters:
WIDTH, 6, stimulus/target width in bits; legal range 2..16
DEC_BITS, 3, decoder input width; onehot width is 2^DEC_BITS; legal range 1..WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a sweep from IDLE or DONE
hold  input  1  when 1 in SWEEP, freezes all state and outputs
mode  input  2  relation, latched at start: 00 eq, 01 lt, 10 gt, 11 ne (stim REL target)
target  input  WIDTH  compare value, latched at start
stim  output  WIDTH  current swept value
match  output  1  relation result for current stim
onehot  output  2^DEC_BITS  one-hot decode of stim[DEC_BITS-1:0]
hit_count  output  WIDTH+1  number of matches so far in this sweep
busy  output  1  1 while in SWEEP
done  output  1  1 while in DONE

Behaviour:
- Single clock domain; reset is synchronous and active-high; all outputs are registered.
- Reset values: state IDLE; stim=0, match=0, onehot=0, hit_count=0, busy=0, done=0; latched mode=00, latched target=0.
- rst has priority over every other input, including mid-sweep; the next cycle is IDLE with reset values.
- States: IDLE, SWEEP, DONE.
- IDLE, start=1:
  - Latch mode and target.
  - Next cycle: SWEEP, stim=0.
  - match and onehot computed for 0 with the newly latched values.
  - hit_count = match(0) (0 or 1).
- SWEEP, hold=1: every register holds its value.
- SWEEP, hold=0, stim < 2^WIDTH-1:
  - Next cycle: stim=stim+1, with match and onehot for the new value.
  - hit_count += new match.
- SWEEP, hold=0, stim = 2^WIDTH-1:
  - Next cycle: DONE; stim held at 2^WIDTH-1.
  - match=0, onehot=0; hit_count retained.
  - The counter never wraps to 0 inside a sweep.
- Alignment: stim, match, onehot and hit_count always refer to the same value in the same cycle. There is no extra pipeline skew.
- Latency: start to first valid stim is 1 cycle. A full sweep without hold is 2^WIDTH cycles in SWEEP.
- start while in SWEEP is ignored; mode and target changes during SWEEP are ignored because the latched copies are used.
- DONE:
  - done=1 and busy=0; hit_count stays valid until the next start or rst.
  - start=1: re-latch mode and target and behave exactly as the IDLE start, including the hit_count restart.
- hold outside SWEEP has no effect.
- Compare is unsigned at WIDTH bits. onehot bit k is set iff stim[DEC_BITS-1:0]=k, only in SWEEP; otherwise all zeros.
- hit_count is WIDTH+1 bits so that 2^WIDTH matches fit (mode ne can reach at most 2^WIDTH-1).

Test Plan:
- WIDTH=6, DEC_BITS=3, target=22, mode=eq, start pulse:
  - busy for 64 cycles, then done=1.
  - match high only in the cycle with stim=22.
  - Final hit_count=1.
- Same sweep with mode lt / gt / ne -> final hit_count=22 / 41 / 63; with mode gt, match rises exactly at stim=23.
- Decoder check during the sweep: at stim=13, onehot=8'b0010_0000; at stim=63, onehot=8'b1000_0000; in IDLE and DONE, onehot=0.
- hold=1 for 5 cycles at stim=10 -> stim, match, onehot and hit_count are frozen; after release, stim=11 next cycle; the total SWEEP duration is 64+5 cycles.
- rst=1 at stim=30 -> next cycle all outputs are 0, state IDLE; a later start sweeps cleanly from 0.
- In DONE, change target to 0, mode=eq, pulse start -> new sweep; hit_count is 1 in the first SWEEP cycle (stim=0) and ends at 1. A start pulse mid-sweep changes nothing.

Source files
------------

// File: rtl/sweep_compare_decode.sv
// sweep_compare_decode
// Sweeps a WIDTH-bit counter from 0 to 2^WIDTH-1 on command. Each swept value
// is compared against a target latched at start using a selectable relation,
// and its low DEC_BITS are one-hot decoded. Matches are counted over the sweep.
// stim, match, onehot and hit_count are produced by the same register stage,
// so they always describe the same swept value.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; outputs at reset values
//   S_SWEEP | counter advancing one value per non-held cycle
//   S_DONE  | sweep finished; hit_count valid until the next start or rst
module sweep_compare_decode #(
  parameter int WIDTH    = 6,
  parameter int DEC_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       hold_i,
  input  logic [1:0]                 mode_i,
  input  logic [WIDTH-1:0]           target_i,
  output logic [WIDTH-1:0]           stim_o,
  output logic                       match_o,
  output logic [(1<<DEC_BITS)-1:0]   onehot_o,
  output logic [WIDTH:0]             hit_count_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int OH_W = 1 << DEC_BITS;
  localparam logic [WIDTH-1:0] STIM_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STIM_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  stim_q, stim_d;
  logic              match_q, match_d;
  logic [OH_W-1:0]   onehot_q, onehot_d;
  logic [WIDTH:0]    hit_count_q, hit_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Unsigned relation: 00 eq, 01 lt, 10 gt, 11 ne (value REL target).
  function automatic logic rel_f(input logic [WIDTH-1:0] v,
                                 input logic [1:0]       m,
                                 input logic [WIDTH-1:0] t);
    logic r;
    r = 1'b0;
    case (m)
      2'b00:   r = (v == t);
      2'b01:   r = (v < t);
      2'b10:   r = (v > t);
      default: r = (v != t);
    endcase
    return r;
  endfunction

  function automatic logic [OH_W-1:0] decode_f(input logic [WIDTH-1:0] v);
    logic [OH_W-1:0] r;
    r = '0;
    r[v[DEC_BITS-1:0]] = 1'b1;
    return r;
  endfunction

  // Next-state and next-output logic; every register holds by default, which
  // also covers hold in SWEEP and the ignored start during a sweep.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    target_d    = target_q;
    stim_d      = stim_q;
    match_d     = match_q;
    onehot_d    = onehot_q;
    hit_count_d = hit_count_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_SWEEP;
          mode_d      = mode_i;
          target_d    = target_i;
          stim_d      = '0;
          // Relation for value 0 uses the freshly latched inputs.
          match_d     = rel_f('0, mode_i, target_i);
          onehot_d    = decode_f('0);
          hit_count_d = {{WIDTH{1'b0}}, match_d};
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
      S_SWEEP: begin
        if (!hold_i) begin
          if (stim_q == STIM_MAX) begin
            // Counter parks at its maximum; it never wraps inside a sweep.
            state_d  = S_DONE;
            match_d  = 1'b0;
            onehot_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            stim_d      = stim_q + STIM_ONE;
            match_d     = rel_f(stim_d, mode_q, target_q);
            onehot_d    = decode_f(stim_d);
            hit_count_d = hit_count_q + {{WIDTH{1'b0}}, match_d};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      target_q    <= '0;
      stim_q      <= '0;
      match_q     <= 1'b0;
      onehot_q    <= '0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      stim_q      <= stim_d;
      match_q     <= match_d;
      onehot_q    <= onehot_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign stim_o      = stim_q;
  assign match_o     = match_q;
  assign onehot_o    = onehot_q;
  assign hit_count_o = hit_count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sweep_compare_decode.sv
// Bench for sweep_compare_decode (WIDTH=6, DEC_BITS=3). A behavioural model
// predicts the outputs after every clock; the prediction is queued when the
// inputs are driven and popped for comparison after the edge. Directed checks
// cover the sweep totals, decoder points, hold, reset and restart cases.
module tb_sweep_compare_decode;

  localparam int W  = 6;
  localparam int DB = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          hold_i = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic [W-1:0]  target_i = '0;
  logic [W-1:0]  stim_o;
  logic          match_o;
  logic [7:0]    onehot_o;
  logic [W:0]    hit_count_o;
  logic          busy_o;
  logic          done_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic [23:0] exp_q[$];

  // model state: 0 idle, 1 sweep, 2 done
  int       m_state = 0;
  bit [1:0] m_mode = 0;
  int       m_tgt = 0;
  int       m_stim = 0;
  int       m_hits = 0;

  sweep_compare_decode #(.WIDTH(W), .DEC_BITS(DB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hold_i(hold_i),
    .mode_i(mode_i), .target_i(target_i), .stim_o(stim_o), .match_o(match_o),
    .onehot_o(onehot_o), .hit_count_o(hit_count_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit tb_rel(input bit [1:0] m, input int v, input int t);
    case (m)
      2'd0: return v == t;
      2'd1: return v < t;
      2'd2: return v > t;
      default: return v != t;
    endcase
  endfunction

  function automatic logic [23:0] model_vec();
    bit       mt;
    bit [7:0] oh;
    mt = (m_state == 1) ? tb_rel(m_mode, m_stim, m_tgt) : 1'b0;
    oh = (m_state == 1) ? 8'(1 << (m_stim % 8)) : 8'h00;
    return {6'(m_stim), mt, oh, 7'(m_hits), m_state == 1, m_state == 2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, wait for the edge, compare.
  task automatic cyc(input bit r, input bit s, input bit h,
                     input bit [1:0] md, input int tg);
    logic [23:0] e;
    rst_i = r; start_i = s; hold_i = h; mode_i = md; target_i = W'(tg);
    if (r) begin
      m_state = 0; m_mode = 0; m_tgt = 0; m_stim = 0; m_hits = 0;
    end else if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_mode = md; m_tgt = tg; m_stim = 0;
        m_hits = int'(tb_rel(md, 0, tg));
      end
    end else if (!h) begin
      if (m_stim == 63) m_state = 2;
      else begin
        m_stim++;
        m_hits += int'(tb_rel(m_mode, m_stim, m_tgt));
      end
    end
    exp_q.push_back(model_vec());
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    chk("cycle", {8'h0, stim_o, match_o, onehot_o, hit_count_o, busy_o, done_o}, {8'h0, e});
  endtask

  // Full sweep with optional hold window and optional ignored mid-sweep start.
  task automatic run_sweep(input bit [1:0] md, input int tg, input int hold_at,
                           input int hold_len, input int poke_at,
                           input int exp_hits, input int exp_busy);
    int busy_n, held, guard;
    bit poked, h, s;
    busy_n = 0; held = 0; guard = 0; poked = 0;
    cyc(0, 1, 0, md, tg);
    chk("first_hit", 32'(hit_count_o), 32'(tb_rel(md, 0, tg)));
    if (busy_o) busy_n++;
    while (!done_o && guard < 200) begin
      h = (int'(stim_o) == hold_at) && (held < hold_len);
      s = (int'(stim_o) == poke_at) && !poked;
      if (h) held++;
      if (s) poked = 1;
      if (s) cyc(0, 1, h, ~md, 5);
      else   cyc(0, 0, h, md, tg);
      if (busy_o) busy_n++;
      if (busy_o && stim_o == 6'd13) chk("onehot13", 32'(onehot_o), 32'h20);
      if (busy_o && stim_o == 6'd63) chk("onehot63", 32'(onehot_o), 32'h80);
      if (md == 2'd2 && busy_o && stim_o == 6'd22) chk("gt_at22", 32'(match_o), 0);
      if (md == 2'd2 && busy_o && stim_o == 6'd23) chk("gt_at23", 32'(match_o), 1);
      if (held == hold_len && hold_len > 0 && !h && int'(stim_o) == hold_at + 1 && busy_o)
        chk("hold_release", 32'(stim_o), 32'(hold_at + 1));
      guard++;
    end
    chk("sweep_timeout", 32'(guard < 200), 1);
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    chk("final_hits", 32'(hit_count_o), 32'(exp_hits));
    chk("done_out", {29'h0, done_o, busy_o, match_o}, 32'h4);
    chk("done_onehot", 32'(onehot_o), 0);
    chk("done_stim", 32'(stim_o), 63);
  endtask

  initial begin
    int guard;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_outputs", {8'h0, stim_o, match_o, onehot_o, hit_count_o, busy_o, done_o}, 0);
    cyc(0, 0, 1, 2'd3, 9);  // hold in IDLE does nothing
    chk("idle_onehot", 32'(onehot_o), 0);

    run_sweep(2'd0, 22, -1, 0, -1, 1, 64);
    run_sweep(2'd1, 22, -1, 0, -1, 22, 64);
    run_sweep(2'd2, 22, -1, 0, -1, 41, 64);
    run_sweep(2'd3, 22, -1, 0, -1, 63, 64);
    run_sweep(2'd0, 22, 10, 5, -1, 1, 69);

    // reset mid-sweep at stim=30
    cyc(0, 1, 0, 2'd1, 40);
    guard = 0;
    while (stim_o != 6'd30 && guard < 100) begin
      cyc(0, 0, 0, 2'd1, 40);
      guard++;
    end
    chk("reach30_timeout", 32'(guard < 100), 1);
    cyc(1, 0, 0, 2'd1, 40);
    chk("midsweep_reset", {8'h0, stim_o, match_o, onehot_o, hit_count_o, busy_o, done_o}, 0);
    cyc(0, 0, 0, 2'd1, 40);
    chk("stays_idle", 32'(busy_o), 0);
    run_sweep(2'd0, 22, -1, 0, -1, 1, 64);

    // restart from DONE with target 0, plus an ignored start mid-sweep
    cyc(0, 0, 1, 2'd0, 0);  // hold in DONE does nothing
    run_sweep(2'd0, 0, -1, 0, 20, 1, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
